// File: rtl/controle_busca.sv
// Instruction-fetch sequencer: owns the PC, reads the ROM, and buffers {pc, instrucao}
// pairs in a small in-order FIFO for decode. A redirect flushes the FIFO and restarts fetch.
//
//  state | meaning
//  RUN   | fetch one word per edge into the FIFO
//  STALL | FIFO filled with no pop; wait for decode to take an entry
//  HALT  | next PC would be past the ROM; only a redirect restarts fetch
module controle_busca #(
    parameter int              PC_W       = 64,
    parameter int              ROM_DEPTH  = 64,
    parameter int              FIFO_DEPTH = 2,
    parameter logic [PC_W-1:0] RESET_PC   = '0
) (
    input  logic            clock,
    input  logic            reset_n,
    output logic [PC_W-1:0] pc,
    input  logic [31:0]     instrucao,
    output logic            inst_valid,
    input  logic            inst_ready,
    output logic [31:0]     inst_out,
    output logic [PC_W-1:0] inst_pc,
    input  logic            redirect,
    input  logic [PC_W-1:0] redirect_pc,
    output logic            halt
);

    localparam int              PTR_W    = $clog2(FIFO_DEPTH);
    localparam int              CNT_W    = PTR_W + 1;
    localparam logic [PC_W-1:0] ROM_LIM  = PC_W'(ROM_DEPTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FIFO_DEPTH);

    typedef enum logic [1:0] {RUN, STALL, HALT} state_t;

    state_t            state, state_nxt;
    logic [PC_W-1:0]   mem_pc   [FIFO_DEPTH];
    logic [31:0]       mem_inst [FIFO_DEPTH];
    logic [PTR_W-1:0]  rd_ptr, wr_ptr;
    logic [CNT_W-1:0]  count;
    logic [PC_W-1:0]   pc_inc;
    logic              not_empty, pop, push;

    assign not_empty = (count != '0);
    assign pop       = not_empty & inst_ready;
    assign push      = (state == RUN) & ((count < CNT_FULL) | pop);
    assign pc_inc    = pc + PC_W'(1);

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) state <= RUN;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (redirect) begin
            state_nxt = (redirect_pc < ROM_LIM) ? RUN : HALT;
        end else begin
            case (state)
                RUN: begin
                    if (!push)
                        state_nxt = STALL;
                    else if (pc_inc >= ROM_LIM)
                        state_nxt = HALT;
                    else if ((count == CNT_FULL - CNT_W'(1)) && !pop)
                        state_nxt = STALL;
                end
                STALL:   if (pop) state_nxt = RUN;
                HALT:    state_nxt = HALT;
                default: state_nxt = RUN;
            endcase
        end
    end

    // Head fields read as zero whenever the FIFO is empty, matching reset.
    always_comb begin
        halt       = (state == HALT);
        inst_valid = not_empty;
        inst_out   = not_empty ? mem_inst[rd_ptr] : '0;
        inst_pc    = not_empty ? mem_pc[rd_ptr]   : '0;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            pc     <= RESET_PC;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (redirect) begin
            pc     <= redirect_pc;
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                pc     <= pc_inc;
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (push && !redirect) begin
            mem_pc[wr_ptr]   <= pc;
            mem_inst[wr_ptr] <= instrucao;
        end
    end

endmodule

// File: tb/tb_controle_busca.sv
// Bench for controle_busca: directed fetch scenarios plus randomized ready/redirect traffic,
// checked against a queue-based model of the fetch buffer.
module tb_controle_busca;

    localparam int D   = 2;
    localparam int LIM = 64;

    logic        clock, reset_n;
    logic [63:0] pc, inst_pc, redirect_pc;
    logic [31:0] instrucao, inst_out;
    logic        inst_valid, inst_ready, redirect, halt;

    logic [31:0] rom [LIM];

    typedef struct {
        logic [63:0] p;
        logic [31:0] i;
    } ent_t;

    ent_t        q[$];
    logic [63:0] mpc;
    bit          halted, stalled;
    int          checks, failures;

    controle_busca dut (
        .clock(clock), .reset_n(reset_n), .pc(pc), .instrucao(instrucao),
        .inst_valid(inst_valid), .inst_ready(inst_ready), .inst_out(inst_out),
        .inst_pc(inst_pc), .redirect(redirect), .redirect_pc(redirect_pc), .halt(halt)
    );

    assign instrucao = (pc < 64'(LIM)) ? rom[pc[5:0]] : 32'hDEAD_BEEF;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic compare_all(input string tag);
        chk({tag, ":pc"}, pc, mpc);
        chk({tag, ":valid"}, 64'(inst_valid), 64'(q.size() != 0));
        chk({tag, ":halt"}, 64'(halt), 64'(halted));
        if (q.size() != 0) begin
            chk({tag, ":inst_pc"}, inst_pc, q[0].p);
            chk({tag, ":inst_out"}, 64'(inst_out), 64'(q[0].i));
        end
    endtask

    task automatic model_reset();
        q.delete();
        mpc     = 64'd0;
        halted  = 1'b0;
        stalled = 1'b0;
    endtask

    // Called shortly after a rising edge; reset is applied and released between edges.
    task automatic do_reset(input string tag);
        reset_n = 1'b0;
        #1;
        model_reset();
        chk({tag, ":rst_pc"}, pc, 64'd0);
        chk({tag, ":rst_valid"}, 64'(inst_valid), 64'd0);
        chk({tag, ":rst_out"}, 64'(inst_out), 64'd0);
        chk({tag, ":rst_ipc"}, inst_pc, 64'd0);
        chk({tag, ":rst_halt"}, 64'(halt), 64'd0);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic step(input string tag, input bit rdy, input bit redir, input logic [63:0] rpc);
        bit mpop, mpush;
        inst_ready  = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        @(posedge clock);
        mpop = (q.size() != 0) && rdy;
        if (redir) begin
            q.delete();
            mpc     = rpc;
            halted  = (rpc >= 64'(LIM));
            stalled = 1'b0;
        end else begin
            mpush = !halted && !stalled && ((q.size() < D) || mpop);
            if (mpop) void'(q.pop_front());
            if (mpush) begin
                q.push_back('{p: mpc, i: rom[mpc[5:0]]});
                if (mpc + 64'd1 >= 64'(LIM))
                    halted = 1'b1;
                else if (q.size() == D && !mpop)
                    stalled = 1'b1;
                mpc = mpc + 64'd1;
            end else if (stalled && mpop) begin
                stalled = 1'b0;
            end
        end
        #1;
        compare_all(tag);
    endtask

    initial begin
        logic [63:0] rpc;
        checks   = 0;
        failures = 0;
        for (int k = 0; k < LIM; k++) rom[k] = $urandom;
        rom[0]  = 32'h0000_0000;
        rom[1]  = 32'h0070_2083;
        rom[10] = 32'hFFFF_1EE3;
        rom[13] = 32'h0000_0D17;
        reset_n     = 1'b0;
        inst_ready  = 1'b0;
        redirect    = 1'b0;
        redirect_pc = '0;
        #1;
        do_reset("t1");

        // T1: streaming from reset
        for (int k = 0; k < 6; k++) step("t1", 1'b1, 1'b0, '0);

        // T2: decode stalled for 5 cycles, then drains
        @(posedge clock); #1;
        do_reset("t2");
        for (int k = 0; k < 5; k++) step("t2_hold", 1'b0, 1'b0, '0);
        chk("t2:pc_held", pc, 64'd2);
        for (int k = 0; k < 5; k++) step("t2_drain", 1'b1, 1'b0, '0);

        // T3: redirect while the FIFO is full
        for (int k = 0; k < 3; k++) step("t3_fill", 1'b0, 1'b0, '0);
        step("t3_redir", 1'b0, 1'b1, 64'd10);
        step("t3_first", 1'b0, 1'b0, '0);
        chk("t3:out10", 64'(inst_out), 64'hFFFF_1EE3);
        for (int k = 0; k < 3; k++) step("t3_run", 1'b1, 1'b0, '0);

        // T4: run off the end of the ROM
        step("t4_redir", 1'b1, 1'b1, 64'd60);
        for (int k = 0; k < 8; k++) step("t4_run", 1'b1, 1'b0, '0);
        chk("t4:halt", 64'(halt), 64'd1);
        chk("t4:pc64", pc, 64'd64);

        // T5: leave HALT by redirect, then redirect out of range
        step("t5_redir", 1'b0, 1'b1, 64'd13);
        step("t5_first", 1'b0, 1'b0, '0);
        chk("t5:auipc", 64'(inst_out), 64'h0000_0D17);
        step("t5_far", 1'b1, 1'b1, 64'd100);
        step("t5_far2", 1'b1, 1'b0, '0);
        // Upper PC bits must count in the range test
        step("t5_wide", 1'b1, 1'b1, 64'h1_0000_0005);
        step("t5_wide2", 1'b1, 1'b0, '0);

        // Random traffic with a mid-stream async reset (T6)
        step("rnd_start", 1'b1, 1'b1, 64'd0);
        for (int k = 0; k < 400; k++) begin
            if (k == 200) do_reset("t6");
            rpc = ($urandom_range(0, 9) == 0) ? {$urandom, $urandom} : 64'($urandom_range(0, 70));
            step("rnd", ($urandom_range(0, 3) != 0), ($urandom_range(0, 15) == 0), rpc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
